// File: rtl/ibex_rf_rollback_ctrl.sv
// Rollback sequencer for the lockstep main/shadow register file pair.
// On a mismatch it stalls and drains the core, copies the shadow file into
// the main file, read-back-verifies the copy and retries a bounded number of
// times before going fatal. It also issues single-shot CTC commands.
module ibex_rf_rollback_ctrl #(
  parameter bit RV32E      = 1'b0,
  parameter int DataWidth  = 39,
  parameter int MaxRetries = 3
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 mismatch_i,
  input  logic                 ctc_req_i,
  input  logic                 core_idle_i,
  output logic                 stall_o,
  output logic [4:0]           rf_waddr_o,
  output logic [DataWidth-1:0] rf_wdata_o,
  output logic                 rf_we_o,
  output logic [4:0]           rf_raddr_o,
  input  logic [DataWidth-1:0] rf_rdata_i,
  output logic [4:0]           sh_raddr_o,
  input  logic [DataWidth-1:0] sh_rdata_i,
  output logic                 ctc_cmd_o,
  output logic                 restore_done_o,
  output logic                 ctc_done_o,
  output logic                 fatal_o,
  output logic [2:0]           retry_cnt_o
);

  localparam int         NumWords = RV32E ? 16 : 32;
  localparam logic [4:0] LastAddr = 5'(NumWords - 1);
  localparam logic [2:0] RetryMax = 3'(MaxRetries);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_DRAIN    = 3'd1,
    S_RESTORE  = 3'd2,
    S_VERIFY   = 3'd3,
    S_DONE     = 3'd4,
    S_CTC      = 3'd5,
    S_CTC_WAIT = 3'd6,
    S_FATAL    = 3'd7
  } state_e;

  state_e     r_state, w_state_nxt;
  logic [4:0] r_addr, w_addr_nxt;
  logic [2:0] r_retry, w_retry_nxt;
  logic       r_err, w_err_nxt;
  logic       r_pend, w_pend_nxt;
  logic       r_wait, w_wait_nxt;
  logic       w_diff;

  // Main copy differs from shadow at the address currently being verified.
  assign w_diff = (rf_rdata_i != sh_rdata_i);

  // State, address, retry counter and CTC bookkeeping registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_addr  <= 5'd0;
      r_retry <= 3'd0;
      r_err   <= 1'b0;
      r_pend  <= 1'b0;
      r_wait  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_addr  <= w_addr_nxt;
      r_retry <= w_retry_nxt;
      r_err   <= w_err_nxt;
      r_pend  <= w_pend_nxt;
      r_wait  <= w_wait_nxt;
    end
  end

  // Next-state sequencing; a CTC request that cannot be served now is pended.
  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_retry_nxt = r_retry;
    w_err_nxt   = r_err;
    w_pend_nxt  = r_pend;
    w_wait_nxt  = r_wait;
    case (r_state)
      S_IDLE: begin
        if (mismatch_i) begin
          w_state_nxt = S_DRAIN;
          w_retry_nxt = 3'd0;
        end else if (ctc_req_i || r_pend) begin
          w_state_nxt = S_CTC;
        end
      end
      S_DRAIN: begin
        if (core_idle_i) begin
          w_state_nxt = S_RESTORE;
          w_addr_nxt  = 5'd1;
        end
      end
      S_RESTORE: begin
        if (r_addr == LastAddr) begin
          w_state_nxt = S_VERIFY;
          w_addr_nxt  = 5'd1;
          w_err_nxt   = 1'b0;
        end else begin
          w_addr_nxt = r_addr + 5'd1;
        end
      end
      S_VERIFY: begin
        if (r_addr == LastAddr) begin
          w_addr_nxt = 5'd0;
          if (!(r_err || w_diff)) begin
            w_state_nxt = S_DONE;
          end else begin
            w_retry_nxt = r_retry + 3'd1;
            if (r_retry + 3'd1 == RetryMax) begin
              w_state_nxt = S_FATAL;
            end else begin
              w_state_nxt = S_RESTORE;
              w_addr_nxt  = 5'd1;
            end
          end
        end else begin
          w_addr_nxt = r_addr + 5'd1;
          w_err_nxt  = r_err | w_diff;
        end
      end
      S_DONE: w_state_nxt = S_IDLE;
      S_CTC: begin
        w_pend_nxt  = 1'b0;
        w_wait_nxt  = 1'b0;
        w_state_nxt = S_CTC_WAIT;
      end
      S_CTC_WAIT: begin
        w_wait_nxt = 1'b1;
        if (r_wait) begin
          w_wait_nxt  = 1'b0;
          w_state_nxt = S_IDLE;
        end
      end
      S_FATAL: w_state_nxt = S_FATAL;
      default: w_state_nxt = S_IDLE;
    endcase
    if (ctc_req_i && ((r_state != S_IDLE) || mismatch_i)) w_pend_nxt = 1'b1;
  end

  // Outputs decoded from registered state and address.
  always_comb begin
    stall_o        = (r_state != S_IDLE);
    rf_we_o        = 1'b0;
    rf_waddr_o     = 5'd0;
    rf_wdata_o     = '0;
    rf_raddr_o     = 5'd0;
    sh_raddr_o     = 5'd0;
    ctc_cmd_o      = 1'b0;
    restore_done_o = 1'b0;
    ctc_done_o     = 1'b0;
    fatal_o        = 1'b0;
    retry_cnt_o    = r_retry;
    case (r_state)
      S_RESTORE: begin
        rf_we_o    = 1'b1;
        rf_waddr_o = r_addr;
        rf_wdata_o = sh_rdata_i;
        sh_raddr_o = r_addr;
      end
      S_VERIFY: begin
        rf_raddr_o = r_addr;
        sh_raddr_o = r_addr;
      end
      S_DONE:     restore_done_o = 1'b1;
      S_CTC:      ctc_cmd_o = 1'b1;
      S_CTC_WAIT: ctc_done_o = r_wait;
      S_FATAL:    fatal_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ibex_rf_rollback_ctrl.sv
// Bench for ibex_rf_rollback_ctrl: a 32-register and an RV32E instance, each
// beside a behavioural main/shadow register file model.
module tb_ibex_rf_rollback_ctrl;

  localparam int DW = 39;
  localparam int MR = 3;

  typedef struct packed {
    logic [4:0]    a;
    logic [DW-1:0] d;
  } wr_t;

  logic clk, rst;
  logic          mism[2], ctcreq[2], idle[2];
  logic          stall[2], we[2], ctc_cmd[2], rdone[2], cdone[2], fatal[2];
  logic [4:0]    waddr[2], raddr[2], sh_raddr[2];
  logic [2:0]    rcnt[2];
  logic [DW-1:0] wdata[2], rdata[2], sh_rdata[2];

  logic [DW-1:0] mainrf[2][32];
  logic [DW-1:0] shrf[2][32];
  int            pass_cnt[2], bad_reg[2], bad_passes[2], inv_cnt[2];
  logic          ctc_prev[2];
  int            cur;
  wr_t           wlog[$];
  int            checks, failures;

  ibex_rf_rollback_ctrl #(.RV32E(1'b0), .DataWidth(DW), .MaxRetries(MR)) u_dut32 (
    .clk_i(clk), .rst_i(rst), .mismatch_i(mism[0]), .ctc_req_i(ctcreq[0]),
    .core_idle_i(idle[0]), .stall_o(stall[0]), .rf_waddr_o(waddr[0]),
    .rf_wdata_o(wdata[0]), .rf_we_o(we[0]), .rf_raddr_o(raddr[0]),
    .rf_rdata_i(rdata[0]), .sh_raddr_o(sh_raddr[0]), .sh_rdata_i(sh_rdata[0]),
    .ctc_cmd_o(ctc_cmd[0]), .restore_done_o(rdone[0]), .ctc_done_o(cdone[0]),
    .fatal_o(fatal[0]), .retry_cnt_o(rcnt[0]));

  ibex_rf_rollback_ctrl #(.RV32E(1'b1), .DataWidth(DW), .MaxRetries(MR)) u_dut16 (
    .clk_i(clk), .rst_i(rst), .mismatch_i(mism[1]), .ctc_req_i(ctcreq[1]),
    .core_idle_i(idle[1]), .stall_o(stall[1]), .rf_waddr_o(waddr[1]),
    .rf_wdata_o(wdata[1]), .rf_we_o(we[1]), .rf_raddr_o(raddr[1]),
    .rf_rdata_i(rdata[1]), .sh_raddr_o(sh_raddr[1]), .sh_rdata_i(sh_rdata[1]),
    .ctc_cmd_o(ctc_cmd[1]), .restore_done_o(rdone[1]), .ctc_done_o(cdone[1]),
    .fatal_o(fatal[1]), .retry_cnt_o(rcnt[1]));

  // Combinational register file reads; a selected main word reads back with
  // bit 0 flipped during the first bad_passes verify passes.
  for (genvar g = 0; g < 2; g++) begin : g_rf
    assign sh_rdata[g] = shrf[g][sh_raddr[g]];
    assign rdata[g]    = mainrf[g][raddr[g]] ^
                         DW'(((int'(raddr[g]) == bad_reg[g]) && (pass_cnt[g] <= bad_passes[g])) ? 1 : 0);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: capture write port / CTC / verify-pass activity, step the edge,
  // then update the register file model.
  task automatic cyc();
    logic          we_p[2], inv_p[2], pass_p[2], c_p[2];
    logic [4:0]    wa_p[2];
    logic [DW-1:0] wd_p[2];
    for (int i = 0; i < 2; i++) begin
      we_p[i]   = we[i];
      wa_p[i]   = waddr[i];
      wd_p[i]   = wdata[i];
      c_p[i]    = ctc_cmd[i];
      inv_p[i]  = ctc_cmd[i] && !ctc_prev[i];
      pass_p[i] = (raddr[i] == 5'd1);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (we_p[i]) begin
        mainrf[i][wa_p[i]] = wd_p[i];
        if (i == cur) wlog.push_back('{a: wa_p[i], d: wd_p[i]});
      end
      if (inv_p[i]) begin
        for (int j = 1; j < 32; j++) mainrf[i][j] = ~mainrf[i][j];
        inv_cnt[i]++;
      end
      ctc_prev[i] = c_p[i];
      if (pass_p[i]) pass_cnt[i]++;
    end
  endtask

  task automatic chk_reset(input int inst, input string tag);
    chk(tag, {stall[inst], we[inst], ctc_cmd[inst], rdone[inst], cdone[inst], fatal[inst],
              waddr[inst], raddr[inst], sh_raddr[inst], rcnt[inst], wdata[inst]}, 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic preload(input int inst);
    for (int j = 0; j < 32; j++) begin
      shrf[inst][j]   = DW'({$urandom, $urandom});
      mainrf[inst][j] = DW'({$urandom, $urandom});
    end
  endtask

  // Full rollback: D cycles of drain, main word badr miscompares in the first
  // F verify passes, optional CTC request in the same cycle as the mismatch.
  task automatic run_rb(input int inst, input int d, input int f, input int badr, input bit with_ctc);
    int  n, p, exp_end, end_k, stall_bad, addr_bad, early_we, err_i, sticky_bad;
    bit  fat, end_seen;
    logic end_fatal;
    logic [2:0] end_rc;
    wr_t e;
    n = inst ? 16 : 32;
    cur = inst;
    wlog.delete();
    preload(inst);
    pass_cnt[inst]   = 0;
    bad_reg[inst]    = badr;
    bad_passes[inst] = f;
    inv_cnt[inst]    = 0;
    fat     = (f >= MR);
    p       = fat ? MR : f + 1;
    exp_end = d + 1 + p * 2 * (n - 1) + 1;
    mism[inst]   = 1'b1;
    ctcreq[inst] = with_ctc;
    idle[inst]   = 1'b0;
    cyc();
    mism[inst]   = 1'b0;
    ctcreq[inst] = 1'b0;
    end_seen = 0; end_k = -1; stall_bad = 0; addr_bad = 0; early_we = 0;
    end_fatal = 1'bx; end_rc = 3'bx;
    for (int k = 1; k <= exp_end + 20 && !end_seen; k++) begin
      idle[inst] = (k > d);
      if (stall[inst] !== 1'b1) stall_bad++;
      if (waddr[inst] > 5'(n - 1) || raddr[inst] > 5'(n - 1) || sh_raddr[inst] > 5'(n - 1)) addr_bad++;
      if (we[inst] && waddr[inst] == 5'd0) addr_bad++;
      if (we[inst] && k <= d + 1) early_we++;
      if (rdone[inst] || fatal[inst]) begin
        end_seen  = 1;
        end_k     = k;
        end_fatal = fatal[inst];
        end_rc    = rcnt[inst];
      end
      cyc();
    end
    chk("end_reached", 64'(end_seen), 64'd1);
    chk("end_cycle", 64'(end_k), 64'(exp_end));
    chk("end_is_fatal", 64'(end_fatal), 64'(fat));
    chk("retry_cnt", 64'(end_rc), fat ? 64'(MR) : 64'(p - 1));
    chk("stall_during", 64'(stall_bad), 64'd0);
    chk("addr_range", 64'(addr_bad), 64'd0);
    chk("no_write_in_drain", 64'(early_we), 64'd0);
    chk("write_count", 64'(wlog.size()), 64'(p * (n - 1)));
    err_i = -1;
    for (int i = 0; i < wlog.size() && err_i < 0; i++) begin
      e.a = 5'((i % (n - 1)) + 1);
      e.d = shrf[inst][e.a];
      if (wlog[i] !== e) err_i = i;
    end
    chk("write_order_data", 64'(err_i), 64'hFFFF_FFFF_FFFF_FFFF);
    if (fat) begin
      sticky_bad = 0;
      for (int k = 0; k < 8; k++) begin
        ctcreq[inst] = (k == 2);
        if (!fatal[inst] || !stall[inst] || we[inst] || ctc_cmd[inst]) sticky_bad++;
        cyc();
      end
      ctcreq[inst] = 1'b0;
      chk("fatal_sticky", 64'(sticky_bad), 64'd0);
      do_reset();
      chk_reset(inst, "reset_after_fatal");
      sticky_bad = 0;
      for (int k = 0; k < 5; k++) begin
        if (ctc_cmd[inst] || stall[inst]) sticky_bad++;
        cyc();
      end
      chk("pend_cleared_by_reset", 64'(sticky_bad), 64'd0);
    end else begin
      chk("stall_low_after_done", 64'(stall[inst]), 64'd0);
      err_i = -1;
      for (int j = 1; j < n; j++) if (mainrf[inst][j] !== shrf[inst][j] && err_i < 0) err_i = j;
      chk("main_equals_shadow", 64'(err_i), 64'hFFFF_FFFF_FFFF_FFFF);
      if (with_ctc) begin
        cyc();
        chk("pend_ctc_cmd", {62'd0, ctc_cmd[inst], stall[inst]}, 64'd3);
        cyc();
        chk("pend_ctc_gap", {62'd0, ctc_cmd[inst], cdone[inst]}, 64'd0);
        cyc();
        chk("pend_ctc_done", {62'd0, cdone[inst], stall[inst]}, 64'd3);
        cyc();
        chk("pend_ctc_release", {62'd0, cdone[inst], stall[inst]}, 64'd0);
        chk("inversions", 64'(inv_cnt[inst]), 64'd1);
        err_i = -1;
        for (int j = 1; j < n; j++) if (mainrf[inst][j] !== ~shrf[inst][j] && err_i < 0) err_i = j;
        chk("main_inverted", 64'(err_i), 64'hFFFF_FFFF_FFFF_FFFF);
      end
    end
    idle[inst] = 1'b1;
  endtask

  initial begin
    int hit_k, maxa, late_w;
    checks = 0; failures = 0; cur = 0;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      mism[i] = 1'b0; ctcreq[i] = 1'b0; idle[i] = 1'b1; ctc_prev[i] = 1'b0;
      pass_cnt[i] = 0; bad_reg[i] = 99; bad_passes[i] = 0; inv_cnt[i] = 0;
      for (int j = 0; j < 32; j++) begin
        mainrf[i][j] = '0;
        shrf[i][j]   = '0;
      end
    end
    do_reset();
    chk_reset(0, "reset_values_32");
    chk_reset(1, "reset_values_16");

    run_rb(0, 0, 0, 99, 1'b0);
    run_rb(0, 0, 1, 7, 1'b0);
    run_rb(0, $urandom_range(0, 4), $urandom_range(0, 2), $urandom_range(2, 31), 1'b0);
    run_rb(1, 5, 0, 99, 1'b0);
    run_rb(0, 0, 99, 7, 1'b0);
    run_rb(0, 0, 0, 99, 1'b1);

    // Standalone CTC from IDLE.
    inv_cnt[0] = 0;
    ctcreq[0] = 1'b1;
    cyc();
    ctcreq[0] = 1'b0;
    chk("ctc_cmd", {62'd0, ctc_cmd[0], stall[0]}, 64'd3);
    cyc();
    chk("ctc_gap", {62'd0, ctc_cmd[0], cdone[0]}, 64'd0);
    cyc();
    chk("ctc_done", {62'd0, cdone[0], stall[0]}, 64'd3);
    cyc();
    chk("ctc_release", {62'd0, cdone[0], stall[0]}, 64'd0);
    chk("ctc_inversions", 64'(inv_cnt[0]), 64'd1);

    // Reset in the middle of a restore pass.
    cur = 0;
    wlog.delete();
    preload(0);
    bad_reg[0] = 99;
    mism[0] = 1'b1;
    cyc();
    mism[0] = 1'b0;
    hit_k = -1;
    for (int k = 0; k < 50 && hit_k < 0; k++) begin
      if (we[0] && waddr[0] == 5'd9) begin
        hit_k = k;
        rst = 1'b1;
      end
      cyc();
    end
    rst = 1'b0;
    chk("mid_reset_reached", 64'(hit_k >= 0), 64'd1);
    chk_reset(0, "mid_reset_idle");
    late_w = wlog.size();
    for (int k = 0; k < 40; k++) cyc();
    maxa = 0;
    foreach (wlog[i]) if (int'(wlog[i].a) > maxa) maxa = int'(wlog[i].a);
    chk("mid_reset_max_addr", 64'(maxa), 64'd9);
    chk("mid_reset_no_more_writes", 64'(wlog.size()), 64'(late_w));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
